// File: rtl/tff_pkg.sv
// Shared mode encodings and end-value helpers for the T-cell counter family.
package tff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_TOGGLE = 2'b00;
  localparam mode_t MODE_UP     = 2'b01;
  localparam mode_t MODE_DOWN   = 2'b10;
  localparam mode_t MODE_GRAY   = 2'b11;

  // End values are returned 32 bits wide; callers keep the low WIDTH bits.
  function automatic logic [31:0] up_end(input int width);
    return 32'hFFFF_FFFF >> (32 - width);
  endfunction

  function automatic logic [31:0] down_end(input int width);
    return 32'h0000_0000 & (32'hFFFF_FFFF >> (32 - width));
  endfunction

  function automatic logic [31:0] gray_end(input int width);
    return 32'h0000_0001 << (width - 1);
  endfunction

endpackage

// File: rtl/tff_cell.sv
// One-bit T flip-flop: q flips on each rising edge where t is high.
// State visible one clock after t is sampled; async active-high reset to RST_VAL.
module tff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tff_multimode_counter.sv
// WIDTH-bit toggle bank / up / down / Gray counter built from T-cells, with load and saturation.
// q and wrap update one clock after the sampling edge; tc is combinational from q and mode.
module tff_multimode_counter
  import tff_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [31:0]      UP_END_W   = up_end(WIDTH);
  localparam logic [31:0]      DOWN_END_W = down_end(WIDTH);
  localparam logic [31:0]      GRAY_END_W = gray_end(WIDTH);
  localparam logic [WIDTH-1:0] UP_END     = UP_END_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] DOWN_END   = DOWN_END_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] GRAY_END   = GRAY_END_W[WIDTH-1:0];

  logic [WIDTH-1:0] q_vec;
  logic [WIDTH-1:0] tv;
  logic [WIDTH-1:0] tv_up;
  logic [WIDTH-1:0] tv_down;
  logic [WIDTH-1:0] tv_gray;
  logic [WIDTH-1:0] low_set;
  logic             sat_hold;
  logic             wrap_d;
  logic             wrap_q;

  // Ripple-carry style toggle terms: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic acc_up;
    logic acc_dn;
    tv_up   = '0;
    tv_down = '0;
    acc_up  = 1'b1;
    acc_dn  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tv_up[i]   = acc_up;
      tv_down[i] = acc_dn;
      acc_up     = acc_up & q_vec[i];
      acc_dn     = acc_dn & ~q_vec[i];
    end
  end

  // Odd parity: flip the bit above the lowest set bit, or the MSB itself when it is the lowest.
  always_comb begin
    low_set = q_vec & (~q_vec + {{(WIDTH-1){1'b0}}, 1'b1});
    if (^q_vec == 1'b0) begin
      tv_gray = {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      tv_gray = {low_set[WIDTH-2:0], 1'b0} | {low_set[WIDTH-1], {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    tc = 1'b0;
    case (mode)
      MODE_UP:   tc = (q_vec == UP_END);
      MODE_DOWN: tc = (q_vec == DOWN_END);
      MODE_GRAY: tc = (q_vec == GRAY_END);
      default:   tc = 1'b0;
    endcase
  end

  always_comb begin
    sat_hold = sat && tc && ((mode == MODE_UP) || (mode == MODE_DOWN));
  end

  always_comb begin
    tv = '0;
    if (load) begin
      tv = q_vec ^ d;
    end else if (en && !sat_hold) begin
      case (mode)
        MODE_TOGGLE: tv = t;
        MODE_UP:     tv = tv_up;
        MODE_DOWN:   tv = tv_down;
        default:     tv = tv_gray;
      endcase
    end
  end

  // Any enabled, unsaturated step taken from the end value lands on the opposite end.
  always_comb begin
    wrap_d = !load && en && tc && !sat_hold;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell #(
      .RST_VAL(RESET_VALUE[i])
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .t  (tv[i]),
      .q  (q_vec[i])
    );
  end

  assign q    = q_vec;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_tff_multimode_counter.sv
// Directed checks of the 4-bit multimode T-cell counter, plus a RESET_VALUE=1010 instance.
module tb_tff_multimode_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] t;
  logic       load;
  logic [3:0] d;
  logic       sat;
  logic [3:0] q;
  logic       tc;
  logic       wrap;
  logic [3:0] q2;
  logic       tc2;
  logic       wrap2;

  int checks;
  int errors;

  tff_multimode_counter #(.WIDTH(4), .RESET_VALUE(4'b0000)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load(load), .d(d),
    .sat(sat), .q(q), .tc(tc), .wrap(wrap)
  );

  tff_multimode_counter #(.WIDTH(4), .RESET_VALUE(4'b1010)) dut_rv (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load(load), .d(d),
    .sat(sat), .q(q2), .tc(tc2), .wrap(wrap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1;
    d    = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL reset_q got %b want 0000", q); end
    checks++;
    if (q2 !== 4'b1010) begin errors++; $display("FAIL reset_q_rv got %b want 1010", q2); end
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
    rst = 1'b0;
    do_load(4'b0110);
    checks++;
    if (q !== 4'b0110) begin errors++; $display("FAIL preload_0110 got %b want 0110", q); end
    mode = 2'b01;
    en   = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL async_rst_q got %b want 0000", q); end
    checks++;
    if (q2 !== 4'b1010) begin errors++; $display("FAIL async_rst_q_rv got %b want 1010", q2); end
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL async_rst_wrap got %b want 0", wrap); end
    tick();
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL rst_held_q got %b want 0000", q); end
    #2;
    rst = 1'b0;
    en  = 1'b0;
  endtask

  task automatic test_up_wrap();
    mode = 2'b01; sat = 1'b0; en = 1'b0;
    do_load(4'b1110);
    en = 1'b1;
    tick();
    checks++;
    if (q !== 4'b1111 || tc !== 1'b1 || wrap !== 1'b0) begin
      errors++; $display("FAIL up_to_max got q=%b tc=%b wrap=%b want 1111 1 0", q, tc, wrap);
    end
    tick();
    checks++;
    if (q !== 4'b0000 || wrap !== 1'b1 || tc !== 1'b0) begin
      errors++; $display("FAIL up_wrap got q=%b tc=%b wrap=%b want 0000 0 1", q, tc, wrap);
    end
    tick();
    checks++;
    if (q !== 4'b0001 || wrap !== 1'b0) begin
      errors++; $display("FAIL up_after_wrap got q=%b wrap=%b want 0001 0", q, wrap);
    end
    en = 1'b0;
  endtask

  task automatic test_up_sat();
    mode = 2'b01; sat = 1'b1; en = 1'b0;
    do_load(4'b1110);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== 4'b1111 || wrap !== 1'b0 || tc !== 1'b1) begin
        errors++; $display("FAIL up_sat step %0d got q=%b tc=%b wrap=%b want 1111 1 0", i, q, tc, wrap);
      end
    end
    en = 1'b0; sat = 1'b0;
  endtask

  task automatic test_down_wrap();
    mode = 2'b10; sat = 1'b0; en = 1'b0;
    do_load(4'b0001);
    en = 1'b1;
    tick();
    checks++;
    if (q !== 4'b0000 || tc !== 1'b1 || wrap !== 1'b0) begin
      errors++; $display("FAIL down_to_zero got q=%b tc=%b wrap=%b want 0000 1 0", q, tc, wrap);
    end
    tick();
    checks++;
    if (q !== 4'b1111 || wrap !== 1'b1 || tc !== 1'b0) begin
      errors++; $display("FAIL down_wrap got q=%b tc=%b wrap=%b want 1111 0 1", q, tc, wrap);
    end
    tick();
    checks++;
    if (q !== 4'b1110 || wrap !== 1'b0) begin
      errors++; $display("FAIL down_after_wrap got q=%b wrap=%b want 1110 0", q, wrap);
    end
    en = 1'b0;
  endtask

  task automatic test_gray();
    logic [3:0] seq [16];
    logic [3:0] prev;
    int         nchg;
    seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
            4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    mode = 2'b11; sat = 1'b1; en = 1'b0;
    do_load(4'b0000);
    en   = 1'b1;
    prev = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      tick();
      nchg = $countones(q ^ prev);
      checks++;
      if (q !== seq[i] || nchg != 1) begin
        errors++; $display("FAIL gray step %0d got %b (%0d bits changed) want %b", i, q, nchg, seq[i]);
      end
      checks++;
      if (tc !== (seq[i] == 4'b1000)) begin
        errors++; $display("FAIL gray_tc step %0d got %b at q=%b", i, tc, q);
      end
      checks++;
      if (wrap !== (i == 15)) begin
        errors++; $display("FAIL gray_wrap step %0d got %b want %b", i, wrap, (i == 15));
      end
      prev = q;
    end
    en = 1'b0; sat = 1'b0;
  endtask

  task automatic test_toggle();
    mode = 2'b00; en = 1'b0;
    do_load(4'b0101);
    t  = 4'b0011;
    en = 1'b1;
    tick();
    checks++;
    if (q !== 4'b0110 || tc !== 1'b0 || wrap !== 1'b0) begin
      errors++; $display("FAIL toggle got q=%b tc=%b wrap=%b want 0110 0 0", q, tc, wrap);
    end
    en = 1'b0;
    t  = 4'b1111;
    tick();
    checks++;
    if (q !== 4'b0110 || tc !== 1'b0 || wrap !== 1'b0) begin
      errors++; $display("FAIL toggle_hold got q=%b tc=%b wrap=%b want 0110 0 0", q, tc, wrap);
    end
    en = 1'b1;
    t  = 4'b1001;
    tick();
    checks++;
    if (q !== 4'b1111 || tc !== 1'b0 || wrap !== 1'b0) begin
      errors++; $display("FAIL toggle_to_ones got q=%b tc=%b wrap=%b want 1111 0 0", q, tc, wrap);
    end
    tick();
    checks++;
    if (q !== 4'b0110 || wrap !== 1'b0) begin
      errors++; $display("FAIL toggle_no_wrap got q=%b wrap=%b want 0110 0", q, wrap);
    end
    en = 1'b0;
    t  = 4'b0000;
  endtask

  task automatic test_load_priority();
    mode = 2'b01; sat = 1'b0; en = 1'b0;
    do_load(4'b0011);
    en = 1'b1;
    do_load(4'b1111);
    checks++;
    if (q !== 4'b1111 || wrap !== 1'b0) begin
      errors++; $display("FAIL load_over_en got q=%b wrap=%b want 1111 0", q, wrap);
    end
    tick();
    checks++;
    if (q !== 4'b0000 || wrap !== 1'b1) begin
      errors++; $display("FAIL load_then_wrap got q=%b wrap=%b want 0000 1", q, wrap);
    end
    en = 1'b0;
    do_load(4'b1111);
    en = 1'b1;
    do_load(4'b0000);
    checks++;
    if (q !== 4'b0000 || wrap !== 1'b0) begin
      errors++; $display("FAIL load_zero_no_wrap got q=%b wrap=%b want 0000 0", q, wrap);
    end
    sat = 1'b1;
    do_load(4'b1001);
    checks++;
    if (q !== 4'b1001) begin
      errors++; $display("FAIL load_ignores_sat got q=%b want 1001", q);
    end
    en = 1'b0; sat = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b1;
    en   = 1'b0;
    mode = 2'b00;
    t    = 4'b0000;
    load = 1'b0;
    d    = 4'b0000;
    sat  = 1'b0;
    test_reset();
    test_up_wrap();
    test_up_sat();
    test_down_wrap();
    test_gray();
    test_toggle();
    test_load_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tff_multimode_counter.md
Name: tff_multimode_counter

Overview:
- Parametrised successor to the single-bit T flip-flop: a WIDTH-bit register built only from T-flip-flop cells.
- Four modes: independent per-bit toggle, binary up count, binary down count and Gray-code up count.
- Adds synchronous parallel load (implemented as a toggle of q^d), optional saturation, a terminal-count flag and a registered wrap pulse.
- Used as a general event counter or toggle bank in datapath and test logic.

Parameters:
- WIDTH, 4, number of bits/T-cells; legal range 2..32.
- RESET_VALUE, 0, value of q after reset; WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- en  input  1  count/toggle enable, sampled on the rising clk edge
- mode  input  2  00 TOGGLE, 01 UP, 10 DOWN, 11 GRAY
- t  input  WIDTH  per-bit toggle request; used only in TOGGLE mode
- load  input  1  synchronous parallel load
- d  input  WIDTH  load data
- sat  input  1  1 = saturate at end value in UP/DOWN; 0 = wrap
- q  output  WIDTH  register state
- tc  output  1  combinational terminal-count flag
- wrap  output  1  registered one-cycle pulse on wrap-around

Behaviour:
- Reset: rst high asynchronously forces q=RESET_VALUE and wrap=0, with no clock needed. While rst is high, load and en are ignored. On release, the first rising edge with rst low applies normal rules.
- Structure: every bit is a T-cell. At each rising edge the cell computes q[i] <= q[i] ^ tv[i], where tv is a combinational toggle vector.
- Priority: load > en.
  - load=1: tv = q ^ d, so q=d next cycle regardless of en, mode or sat. wrap=0 that cycle.
  - load=0, en=0: tv=0. q holds and wrap=0.
  - load=0, en=1: tv depends on mode, as below.
- TOGGLE mode: tv=t.
- UP mode: tv[i] = AND of q[i-1:0], with tv[0]=1.
- DOWN mode: tv[i] = AND of ~q[i-1:0], with tv[0]=1.
- GRAY mode (reflected binary, up only):
  - If parity of q is even, tv toggles bit 0 only.
  - Otherwise let k be the index of the lowest set bit. Toggle bit k+1, or, if k=WIDTH-1, toggle bit WIDTH-1.
  - Exactly one bit toggles per enabled edge.
- End values: UP max = all ones; DOWN end = 0; GRAY end = 1 followed by WIDTH-1 zeros.
- Saturation: with sat=1 in UP or DOWN at the end value, tv=0, so q holds and wrap stays 0. sat has no effect in TOGGLE or GRAY mode; GRAY always wraps.
- tc:
  - 1 when q equals the end value of the current mode.
  - Always 0 in TOGGLE mode.
  - Purely combinational from q and mode; not gated by en.
- wrap:
  - Registered. Goes high for one cycle on the edge where q moves from the end value to the opposite end: UP max->0, DOWN 0->max, GRAY end->0.
  - Never asserts from TOGGLE mode or from a load, even when d equals the wrap target.
- Mode change: takes effect at the next enabled edge. q is not modified by the mode change itself; counting continues from the current q.
  - A non-Gray value in GRAY mode still follows the parity rule above.
- Latency: q reflects an enabled operation one clock after the sampling edge.

Decomposition:
- Shared package tff_pkg holds:
  - mode encodings MODE_TOGGLE=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_GRAY=2'b11;
  - a 2-bit mode typedef;
  - the end-value constants as functions of WIDTH.
- One natural sub-module, tff_cell: a 1-bit T flip-flop with async active-high rst, parameter RST_VAL, and ports clk, rst, t, q. It is instantiated WIDTH times via generate.
- The toggle-vector logic, tc and the wrap register live in the top module.

Test Plan (WIDTH=4, RESET_VALUE=0 unless stated):
- Reset mid-count: UP mode at q=0110, assert rst between edges -> q=0000 immediately, before the next edge, and wrap=0. RESET_VALUE=4'b1010 variant -> q=1010.
- UP wrap vs saturate:
  - sat=0 from 1110, two enabled edges -> q=1111 with tc=1, then q=0000 with wrap=1 for exactly one cycle.
  - sat=1 from 1110 -> q stays 1111, wrap never asserts.
- DOWN from 0001, sat=0 -> q=0000 with tc=1, then q=1111 with wrap=1.
- GRAY: 16 enabled edges from 0000 -> sequence 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000. Exactly one bit changes per step; tc=1 at 1000; wrap=1 after the 16th edge.
- TOGGLE and en:
  - q=0101, t=0011, en=1 -> q=0110.
  - en=0 with t=1111 -> q holds.
  - tc=0 and wrap=0 throughout.
- Load priority: UP mode, q=0011, en=1, load=1, d=1111 -> q=1111, wrap=0. Next edge with load=0, sat=0 -> q=0000, wrap=1. A load of d=0000 while q=1111 -> wrap=0.
